// File: rtl/rf_pkg.sv
// Shared types and default sizing for the register file with busy scoreboard.
package rf_pkg;
  typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t;

  localparam int RF_DW = 8;
  localparam int RF_AW = 3;
  localparam int RF_NR = 2;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: reserve sets, writeback clears, sweep clears one entry
// per cycle. NR combinational lookups feed the read ports.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int NR = RF_NR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            setEn,
  input  logic [AW-1:0]   setAddress,
  input  logic            clrEn,
  input  logic [AW-1:0]   clrAddress,
  input  logic            sweepEn,
  input  logic [AW-1:0]   sweepAddress,
  input  logic [NR*AW-1:0] lookupAddress,
  output logic [NR-1:0]   lookupBusy
);
  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy;

  // Set is applied after clear so a same-address reserve beats the writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else if (sweepEn) begin
      busy[sweepAddress] <= 1'b0;
    end else begin
      if (clrEn) busy[clrAddress] <= 1'b0;
      if (setEn) busy[setAddress] <= 1'b1;
    end
  end

  always_comb begin
    lookupBusy = '0;
    for (int i = 0; i < NR; i++) begin
      lookupBusy[i] = busy[lookupAddress[i*AW +: AW]];
    end
  end
endmodule

// File: rtl/reg_file_sb.sv
// General-purpose register file with busy scoreboard and a 2**AW-cycle clear sweep.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DW = RF_DW,
  parameter int AW = RF_AW,
  parameter int NR = RF_NR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEn,
  input  logic [AW-1:0]    writeAddress,
  input  logic [DW-1:0]    dataInput,
  input  logic             reserveEn,
  input  logic [AW-1:0]    reserveAddress,
  input  logic [NR*AW-1:0] readAddress,
  output logic [NR*DW-1:0] dataOutput,
  output logic [NR-1:0]    readBusy,
  input  logic             clearReq,
  output logic             clearBusy,
  output rf_state_t        fsmState
);
  localparam int DEPTH = 1 << AW;

  rf_state_t      state, state_next;
  logic [AW-1:0]  cnt;
  logic [DW-1:0]  core [DEPTH];
  logic           sweeping;
  logic           wr;
  logic           rsv;
  logic [NR-1:0]  sbBusy;

  // Valid/ready-free handshake: the requester may only pulse clearReq or issue
  // writes/reserves while clearBusy is low; anything presented during a sweep is dropped.
  assign sweeping  = (state == RF_SWEEP);
  assign wr        = !sweeping && writeEn;
  assign rsv       = !sweeping && reserveEn;
  assign clearBusy = sweeping;
  assign fsmState  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= sweeping ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RF_IDLE:  if (clearReq) state_next = RF_SWEEP;
      RF_SWEEP: if (&cnt) state_next = RF_IDLE;
      default:  state_next = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < DEPTH; j++) core[j] <= '0;
    end else if (sweeping) begin
      core[cnt] <= '0;
    end else if (wr) begin
      core[writeAddress] <= dataInput;
    end
  end

  rf_scoreboard #(.AW(AW), .NR(NR)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .setEn        (rsv),
    .setAddress   (reserveAddress),
    .clrEn        (wr),
    .clrAddress   (writeAddress),
    .sweepEn      (sweeping),
    .sweepAddress (cnt),
    .lookupAddress(readAddress),
    .lookupBusy   (sbBusy)
  );

  always_comb begin
    dataOutput = '0;
    readBusy   = sbBusy;
    for (int i = 0; i < NR; i++) begin
      dataOutput[i*DW +: DW] = core[readAddress[i*AW +: AW]];
`ifdef RF_BYPASS_EN
      if (wr && (writeAddress == readAddress[i*AW +: AW])) begin
        dataOutput[i*DW +: DW] = dataInput;
        readBusy[i] = rsv && (reserveAddress == readAddress[i*AW +: AW]);
      end
`else
`endif
    end
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with configurable data width, depth and read-port count, plus a per-register busy scoreboard and a multi-cycle clear sweep. It is the CPU's general-purpose register store. Decode reserves a destination register when a long-latency result is pending. Writeback clears that reservation. Software or the controller can request a full clear without asserting reset.

## Interface
Parameters:
- DW, 8, data width in bits
- AW, 3, address width; depth is 2**AW registers
- NR, 2, number of read ports

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- writeEn  in  1  write enable
- writeAddress  in  AW  write register index
- dataInput  in  DW  write data
- reserveEn  in  1  mark a register busy (result pending)
- reserveAddress  in  AW  register to reserve
- readAddress  in  NR*AW  packed read indices; port i occupies bits [i*AW +: AW]
- dataOutput  out  NR*DW  packed read data; port i occupies bits [i*DW +: DW]
- readBusy  out  NR  busy bit of the register addressed by each read port
- clearReq  in  1  one-cycle request to start a clear sweep
- clearBusy  out  1  high while a clear sweep is in progress

## Operation
- Reset (asynchronous, any time, including mid-sweep):
  - all registers become 0 and all busy bits become 0
  - FSM goes to IDLE and the sweep counter goes to 0
  - clearBusy = 0, dataOutput = 0, readBusy = 0
- Reads are combinational: dataOutput[i] = core[readAddress[i]] and readBusy[i] = busy[readAddress[i]]. Any port may read any address, including the same address as another port.
- Write, in IDLE with writeEn = 1: core[writeAddress] <= dataInput and busy[writeAddress] <= 0.
- Reserve, in IDLE with reserveEn = 1: busy[reserveAddress] <= 1.
- Write and reserve to the same address in the same cycle: data is written and busy ends at 1, because the reservation wins. Different addresses are handled independently.
- FSM has two states, IDLE and SWEEP.
  - IDLE to SWEEP when clearReq = 1 at an edge; the counter is 0 at that point.
  - In SWEEP, each edge writes core[cnt] <= 0 and busy[cnt] <= 0, then increments cnt.
  - SWEEP to IDLE on the edge that clears register 2**AW-1; cnt wraps to 0.
- In SWEEP, writeEn, reserveEn and clearReq are ignored and dropped. The requester must hold off while clearBusy = 1.
- A write or reserve in the same cycle that clearReq is accepted in IDLE is performed normally. The sweep then clears it later.

## Timing
- Read latency is 0 cycles (combinational from the address).
- Write or reserve takes effect at the next edge and is visible on reads after that edge.
- clearReq sampled at edge k:
  - clearBusy is high from just after edge k until just after edge k+2**AW
  - register j is cleared at edge k+1+j
  - total sweep length is 2**AW cycles
- clearBusy is a registered output, derived from the FSM state only.
- Back-to-back clears: clearReq at the final SWEEP edge is ignored. A new request is accepted only once clearBusy = 0.

## Configuration
- RF_BYPASS_EN defined (write-to-read forwarding):
  - Condition: in IDLE with writeEn = 1 and writeAddress == readAddress[i].
  - Then dataOutput[i] = dataInput in the same cycle.
  - readBusy[i] = 1 only if reserveEn = 1 with reserveAddress equal to that address; otherwise 0.
  - No forwarding happens during SWEEP.
- RF_BYPASS_EN undefined: reads return stored state only. New data is visible the cycle after the write.

## Structure
- Shared package rf_pkg holds:
  - typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t
  - default constants RF_DW = 8, RF_AW = 3, RF_NR = 2
- Sub-module rf_scoreboard holds the busy bit vector: set, clear and sweep-clear inputs, plus NR combinational lookups. The data array, FSM and bypass muxes stay in reg_file_sb.

## Test plan
- Reset, then read all 8 addresses on both ports -> every dataOutput = 0x00 and readBusy = 0. Assert reset mid-sweep -> clearBusy drops immediately and all registers read 0.
- Write 0xA5 to r3, then read r3 on port 0 and port 1 the next cycle -> both 0xA5. Without RF_BYPASS_EN, the same-cycle read of r3 returns the old value 0x00; with it, 0xA5.
- Reserve r5 -> readBusy = 1 next cycle. Write 0x3C to r5 -> busy = 0 and data = 0x3C. Write and reserve r5 in the same cycle -> data 0x3C and busy = 1.
- Fill r0..r7 with 0x11..0x88 and pulse clearReq -> clearBusy high for exactly 8 cycles. Register j reads 0 after edge k+1+j and r7 keeps 0x88 until its edge.
- During a sweep, assert writeEn to r2 with 0xFF and reserveEn r4 -> both are dropped. After the sweep, r2 = 0x00 and busy[4] = 0.
- Parameter variant DW = 16, AW = 4, NR = 3: write 0xBEEF to r15 and read it on all three ports -> 0xBEEF. A clear sweep lasts 16 cycles.
